// File: rtl/axi4_line_master_if.sv
// AXI4-full read/write channel bundle between the line master and the SRAM slave.
interface axi4_line_master_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32
);
  logic [3:0]              awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [3:0]              arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi4_line_master.sv
// Cache line refill/writeback master: one INCR burst outstanding, read requests win ties.
module axi4_line_master #(
  parameter int         DATA_WIDTH = 64,
  parameter int         ADDR_WIDTH = 32,
  parameter int         LINE_BEATS = 4,
  parameter logic [3:0] AXI_ID     = 4'd0
) (
  input  logic                             i_aclk,
  input  logic                             i_arsetn,
  input  logic                             i_rd_req,
  input  logic [ADDR_WIDTH-1:0]            i_rd_addr,
  input  logic                             i_wr_req,
  input  logic [ADDR_WIDTH-1:0]            i_wr_addr,
  input  logic [LINE_BEATS*DATA_WIDTH-1:0] i_wr_line,
  output logic                             o_req_ready,
  output logic [LINE_BEATS*DATA_WIDTH-1:0] o_rd_line,
  output logic                             o_rd_done,
  output logic                             o_wr_done,
  output logic                             o_err,
  axi4_line_master_if.master               axi
);

  localparam int CNT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam int OFS_W = $clog2(LINE_BEATS * DATA_WIDTH / 8);
  localparam int SIZE  = $clog2(DATA_WIDTH / 8);
  localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(LINE_BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'((64'd1 << OFS_W) - 64'd1);

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE
  } state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic                    err;
  logic                    is_wr;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   rd_buf [LINE_BEATS];
  logic [DATA_WIDTH-1:0]   wr_buf [LINE_BEATS];
  logic                    unused_resp;

  function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] a);
    return a & LINE_MASK;
  endfunction

  // Beat counter never wraps: surplus read beats keep landing in the last slot.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == LAST_BEAT) ? c : c + 1'b1;
  endfunction

  assign unused_resp = &{1'b0, axi.rresp[0], axi.bresp[0]};

  assign axi.awid    = AXI_ID;
  assign axi.awaddr  = addr;
  assign axi.awlen   = 8'(LINE_BEATS - 1);
  assign axi.awsize  = 3'(SIZE);
  assign axi.awburst = 2'b01;
  assign axi.wdata   = wr_buf[cnt];
  assign axi.wstrb   = '1;
  assign axi.wlast   = (cnt == LAST_BEAT);
  assign axi.arid    = AXI_ID;
  assign axi.araddr  = addr;
  assign axi.arlen   = 8'(LINE_BEATS - 1);
  assign axi.arsize  = 3'(SIZE);
  assign axi.arburst = 2'b01;

  for (genvar k = 0; k < LINE_BEATS; k++) begin : g_line
    assign o_rd_line[k*DATA_WIDTH +: DATA_WIDTH] = rd_buf[k];
  end

  always_ff @(posedge i_aclk) begin
    if (!i_arsetn) state <= S_IDLE;
    else           state <= state_nxt;
  end

  // All handshake outputs decode from the state register only, so no AXI input reaches an AXI output.
  always_comb begin
    state_nxt   = state;
    o_req_ready = 1'b0;
    o_rd_done   = 1'b0;
    o_wr_done   = 1'b0;
    o_err       = 1'b0;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.bready  = 1'b0;
    unique case (state)
      S_IDLE: begin
        o_req_ready = i_arsetn;
        if (i_rd_req)      state_nxt = S_AR;
        else if (i_wr_req) state_nxt = S_AW;
      end
      S_AR: begin
        axi.arvalid = 1'b1;
        if (axi.arready) state_nxt = S_R;
      end
      S_R: begin
        axi.rready = 1'b1;
        if (axi.rvalid && axi.rlast) state_nxt = S_DONE;
      end
      S_AW: begin
        axi.awvalid = 1'b1;
        if (axi.awready) state_nxt = S_W;
      end
      S_W: begin
        axi.wvalid = 1'b1;
        if (axi.wready && cnt == LAST_BEAT) state_nxt = S_B;
      end
      S_B: begin
        axi.bready = 1'b1;
        if (axi.bvalid) state_nxt = S_DONE;
      end
      S_DONE: begin
        o_rd_done = ~is_wr;
        o_wr_done = is_wr;
        o_err     = err;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_aclk) begin
    if (!i_arsetn) begin
      cnt   <= '0;
      err   <= 1'b0;
      is_wr <= 1'b0;
      addr  <= '0;
      for (int k = 0; k < LINE_BEATS; k++) begin
        rd_buf[k] <= '0;
        wr_buf[k] <= '0;
      end
    end else begin
      unique case (state)
        S_IDLE: begin
          if (i_rd_req) begin
            addr  <= line_align(i_rd_addr);
            is_wr <= 1'b0;
          end else if (i_wr_req) begin
            addr  <= line_align(i_wr_addr);
            is_wr <= 1'b1;
            for (int k = 0; k < LINE_BEATS; k++)
              wr_buf[k] <= i_wr_line[k*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        S_R: begin
          if (axi.rvalid) begin
            rd_buf[cnt] <= axi.rdata;
            cnt         <= sat_inc(cnt);
            err         <= err | axi.rresp[1];
          end
        end
        S_AW: if (axi.awready) cnt <= '0;
        S_W:  if (axi.wready)  cnt <= sat_inc(cnt);
        S_B:  if (axi.bvalid)  err <= err | axi.bresp[1];
        S_DONE: begin
          cnt <= '0;
          err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_line_master.sv
// Randomized bench for axi4_line_master: the bench plays the AXI slave and predicts lines, errors and beat order.
module tb_axi4_line_master;
  localparam int DW = 64;
  localparam int AW = 32;
  localparam int LB = 4;
  localparam int LW = LB * DW;
  localparam int LINE_BYTES = LB * DW / 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          rd_req, wr_req;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [LW-1:0] wr_line;
  logic          req_ready, rd_done, wr_done, err;
  logic [LW-1:0] rd_line;
  logic [LW-1:0] last_rd_line;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi4_line_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) axi ();

  axi4_line_master #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LINE_BEATS(LB), .AXI_ID(4'd0)
  ) dut (
    .i_aclk(clk), .i_arsetn(rstn),
    .i_rd_req(rd_req), .i_rd_addr(rd_addr),
    .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_line(wr_line),
    .o_req_ready(req_ready), .o_rd_line(rd_line),
    .o_rd_done(rd_done), .o_wr_done(wr_done), .o_err(err),
    .axi(axi)
  );

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] aligned(input logic [AW-1:0] a);
    return a - (a % LINE_BYTES);
  endfunction

  function automatic logic [DW-1:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int k = 0; k < LB; k++) l[k*DW +: DW] = rand64();
    return l;
  endfunction

  task automatic slave_idle();
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00;
    axi.rdata = '0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int ar_stall, input int err_beat,
                         input bit gaps, input bit wr_pending, input bit fixed_data);
    logic [LW-1:0] exp_line;
    logic          exp_err;
    logic [DW-1:0] d;
    exp_err = 1'b0;
    exp_line = '0;
    rd_req = 1'b1; rd_addr = a;
    check("rd_req_ready", req_ready, 1);
    @(negedge clk);
    rd_req = 1'b0; rd_addr = $urandom;
    check("arvalid", axi.arvalid, 1);
    check("awvalid_in_read", axi.awvalid, 0);
    check("araddr", axi.araddr, aligned(a));
    check("arlen", axi.arlen, LB - 1);
    check("arsize", axi.arsize, 3);
    check("arburst", axi.arburst, 1);
    check("arid", axi.arid, 0);
    check("ready_busy_ar", req_ready, 0);
    for (int s = 0; s < ar_stall; s++) begin
      @(negedge clk);
      check("arvalid_hold", axi.arvalid, 1);
      check("araddr_hold", axi.araddr, aligned(a));
      check("rready_before_ar", axi.rready, 0);
    end
    axi.arready = 1'b1;
    @(negedge clk);
    axi.arready = 1'b0;
    check("arvalid_drop", axi.arvalid, 0);
    for (int b = 0; b < LB; b++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        axi.rvalid = 1'b0;
        @(negedge clk);
        check("rd_done_early", rd_done, 0);
      end
      d = fixed_data ? DW'(64'h11 * (b + 1)) : rand64();
      exp_line[b*DW +: DW] = d;
      check("rready", axi.rready, 1);
      if (wr_pending) check("ready_busy_r", req_ready, 0);
      axi.rvalid = 1'b1;
      axi.rdata  = d;
      axi.rlast  = (b == LB - 1);
      if (b == err_beat) begin
        axi.rresp = {1'b1, 1'($urandom_range(0, 1))};
        exp_err = 1'b1;
      end else begin
        axi.rresp = {1'b0, 1'($urandom_range(0, 1))};
      end
      @(negedge clk);
    end
    axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00;
    check("rd_done", rd_done, 1);
    check("wr_done_in_read", wr_done, 0);
    check("rd_err", err, exp_err);
    check("rd_line", rd_line, exp_line);
    last_rd_line = exp_line;
    @(negedge clk);
    check("rd_done_pulse", rd_done, 0);
    check("rd_line_hold", rd_line, exp_line);
    check("ready_after_read", req_ready, 1);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [LW-1:0] line, input int mode,
                          input int bdelay, input bit berr, input int abort_after);
    int idx, cyc;
    bit rdy;
    wr_req = 1'b1; wr_addr = a; wr_line = line;
    check("wr_req_ready", req_ready, 1);
    @(negedge clk);
    wr_req = 1'b0; wr_addr = $urandom; wr_line = rand_line();
    check("awvalid", axi.awvalid, 1);
    check("arvalid_in_write", axi.arvalid, 0);
    check("awaddr", axi.awaddr, aligned(a));
    check("awlen", axi.awlen, LB - 1);
    check("awsize", axi.awsize, 3);
    check("awburst", axi.awburst, 1);
    check("awid", axi.awid, 0);
    check("wvalid_before_aw", axi.wvalid, 0);
    for (int s = 0; s < int'($urandom_range(0, 2)); s++) begin
      @(negedge clk);
      check("awvalid_hold", axi.awvalid, 1);
      check("wvalid_during_aw", axi.wvalid, 0);
    end
    axi.awready = 1'b1;
    @(negedge clk);
    axi.awready = 1'b0;
    idx = 0; cyc = 0;
    while (idx < LB && cyc < 4 * LB + 8) begin
      if (abort_after >= 0 && idx == abort_after) begin
        axi.wready = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        check("rst_wvalid", axi.wvalid, 0);
        check("rst_bready", axi.bready, 0);
        check("rst_wr_done", wr_done, 0);
        check("rst_rd_done", rd_done, 0);
        check("rst_ready", req_ready, 0);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_idle_ready", req_ready, 1);
        check("rst_no_done", wr_done, 0);
        check("rst_wvalid2", axi.wvalid, 0);
        check("rst_rd_line", rd_line, 0);
        last_rd_line = '0;
        return;
      end
      check("wvalid", axi.wvalid, 1);
      check("wdata", axi.wdata, line[idx*DW +: DW]);
      check("wlast", axi.wlast, (idx == LB - 1));
      check("wstrb", axi.wstrb, 8'hFF);
      check("bready_in_w", axi.bready, 0);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 1);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      axi.wready = rdy;
      @(negedge clk);
      if (rdy) idx++;
      cyc++;
    end
    axi.wready = 1'b0;
    check("w_beats", idx, LB);
    check("wvalid_after_last", axi.wvalid, 0);
    for (int s = 0; s < bdelay; s++) begin
      check("bready_wait", axi.bready, 1);
      check("wr_done_early", wr_done, 0);
      @(negedge clk);
    end
    check("bready", axi.bready, 1);
    axi.bvalid = 1'b1;
    axi.bresp  = {berr, 1'($urandom_range(0, 1))};
    @(negedge clk);
    axi.bvalid = 1'b0; axi.bresp = 2'b00;
    check("wr_done", wr_done, 1);
    check("rd_done_in_write", rd_done, 0);
    check("wr_err", err, berr);
    check("rd_line_kept", rd_line, last_rd_line);
    @(negedge clk);
    check("wr_done_pulse", wr_done, 0);
    check("ready_after_write", req_ready, 1);
  endtask

  initial begin
    logic [LW-1:0] line;
    logic [AW-1:0] a;
    rstn = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_line = '0;
    last_rd_line = '0;
    slave_idle();
    repeat (3) @(negedge clk);
    check("reset_arvalid", axi.arvalid, 0);
    check("reset_awvalid", axi.awvalid, 0);
    check("reset_wvalid", axi.wvalid, 0);
    check("reset_rready", axi.rready, 0);
    check("reset_bready", axi.bready, 0);
    check("reset_rd_done", rd_done, 0);
    check("reset_wr_done", wr_done, 0);
    check("reset_err", err, 0);
    check("reset_req_ready", req_ready, 0);
    check("reset_rd_line", rd_line, 0);
    rstn = 1'b1;
    @(negedge clk);
    check("idle_req_ready", req_ready, 1);

    // Directed refill with known beats.
    do_read(32'h8000_0018, 0, -1, 1'b0, 1'b0, 1'b1);
    check("refill_line", rd_line, {64'h44, 64'h33, 64'h22, 64'h11});

    // Writeback with wready stalling every other cycle.
    do_write(32'h8000_1000, rand_line(), 1, 1, 1'b0, -1);

    // Both requests at once: read first, then the held write.
    line = rand_line();
    wr_req = 1'b1; wr_addr = 32'h0000_2040; wr_line = line;
    do_read(32'h0000_3000, 0, -1, 1'b0, 1'b1, 1'b0);
    do_write(32'h0000_2040, line, 0, 0, 1'b0, -1);

    // Error on beat 2, then a clean read.
    do_read(32'h1234_5678, 0, 2, 1'b0, 1'b0, 1'b0);
    do_read(32'h1234_5678, 0, -1, 1'b0, 1'b0, 1'b0);

    // Reset after two write beats, then a normal read.
    do_write(32'h0000_4000, rand_line(), 0, 0, 1'b0, 2);
    do_read(32'hFFFF_FFFF, 0, -1, 1'b0, 1'b0, 1'b0);

    // Slow arready.
    do_read(32'h0000_00E0, 5, -1, 1'b0, 1'b0, 1'b0);

    // Write with SLVERR/DECERR on B.
    do_write(32'hA5A5_A5A5, rand_line(), 2, 2, 1'b1, -1);

    for (int it = 0; it < 16; it++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 1)
        do_read(a, $urandom_range(0, 3),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, LB - 1)) : -1,
                1'b1, 1'b0, 1'b0);
      else
        do_write(a, rand_line(), 2, $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
